// File: rtl/mac_pkg.sv
// Shared types and defaults for the Wishbone MAC operand fetcher.
package mac_pkg;

    localparam int unsigned NWORDS_DEF  = 8;
    localparam int unsigned RES_W_DEF   = 28;
    localparam int unsigned TIMEOUT_DEF = 255;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    localparam logic [WB_SW-1:0] WB_SEL_ALL = 4'hF;
    localparam logic [WB_AW-1:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_WRITE    = 2'd3
    } mac_state_e;

    // Registered Wishbone initiator request
    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [WB_SW-1:0] sel;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_ack_timer.sv
// Loadable down-counter; expired_o rises on the TIMEOUT-th consecutive tick after a load.
module wb_ack_timer
    import mac_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);
    localparam logic EXP_ON_LOAD = (TIMEOUT <= 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    // Flag is registered one tick early so it is visible during the last allowed cycle
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (load_i) begin
            cnt_d     = LOAD_VAL;
            expired_d = EXP_ON_LOAD;
        end else if (tick_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (cnt_q == CW'(1)) begin
                expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/wb_mac_fetch.sv
// Fetches NWORDS operand words over Wishbone, hands them to a MAC, then writes the
// MAC result back to a destination address.
module wb_mac_fetch
    import mac_pkg::*;
#(
    parameter int unsigned NWORDS  = NWORDS_DEF,
    parameter int unsigned RES_W   = RES_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   start_i,
    input  logic [WB_AW-1:0]       src_adr_i,
    input  logic [WB_AW-1:0]       dst_adr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [WB_SW-1:0]       wbm_sel_o,
    output logic [WB_AW-1:0]       wbm_adr_o,
    output logic [WB_DW-1:0]       wbm_dat_o,
    input  logic [WB_DW-1:0]       wbm_dat_i,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_err_i,
    output logic [NWORDS*WB_DW-1:0] op_data_o,
    output logic                   op_valid_o,
    input  logic [RES_W-1:0]       res_i,
    input  logic                   res_valid_i
);

    localparam int unsigned OPW = NWORDS * WB_DW;
    localparam int unsigned IW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    mac_state_e       state_q, state_d;
    wb_req_t          wb_q, wb_d;
    logic [WB_AW-1:0] dst_q, dst_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [OPW-1:0]   op_data_q, op_data_d;
    logic             op_valid_q, op_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic bus_ack_c, bus_err_c, abort_c;
    logic tmr_load_c, tmr_tick_c, tmr_expired;

    // Responses only count while a strobe is outstanding; error beats ack, ack beats timeout
    assign bus_ack_c  = wbm_ack_i & wb_q.stb;
    assign bus_err_c  = wbm_err_i & wb_q.stb;
    assign abort_c    = bus_err_c | (tmr_expired & ~bus_ack_c);
    assign tmr_tick_c = wb_q.stb & ~bus_ack_c;

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .load_i    (tmr_load_c),
        .tick_i    (tmr_tick_c),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        dst_d      = dst_q;
        idx_d      = idx_q;
        op_data_d  = op_data_q;
        op_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tmr_load_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_READ;
                    wb_d.cyc   = 1'b1;
                    wb_d.stb   = 1'b1;
                    wb_d.we    = 1'b0;
                    wb_d.sel   = WB_SEL_ALL;
                    wb_d.adr   = src_adr_i;
                    dst_d      = dst_adr_i;
                    idx_d      = '0;
                    tmr_load_c = 1'b1;
                end
            end

            ST_READ: begin
                if (abort_c) begin
                    state_d  = ST_IDLE;
                    wb_d.cyc = 1'b0;
                    wb_d.stb = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                end else if (bus_ack_c) begin
                    for (int unsigned w = 0; w < NWORDS; w++) begin
                        if (IW'(w) == idx_q) begin
                            op_data_d[w*WB_DW +: WB_DW] = wbm_dat_i;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_WAIT_RES;
                        wb_d.cyc   = 1'b0;
                        wb_d.stb   = 1'b0;
                        op_valid_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + IW'(1);
                        wb_d.adr   = wb_q.adr + WORD_BYTES;
                        tmr_load_c = 1'b1;
                    end
                end
            end

            ST_WAIT_RES: begin
                if (res_valid_i) begin
                    state_d    = ST_WRITE;
                    wb_d.cyc   = 1'b1;
                    wb_d.stb   = 1'b1;
                    wb_d.we    = 1'b1;
                    wb_d.sel   = WB_SEL_ALL;
                    wb_d.adr   = dst_q;
                    wb_d.dat   = WB_DW'(res_i);
                    tmr_load_c = 1'b1;
                end
            end

            ST_WRITE: begin
                if (abort_c) begin
                    state_d  = ST_IDLE;
                    wb_d.cyc = 1'b0;
                    wb_d.stb = 1'b0;
                    wb_d.we  = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                end else if (bus_ack_c) begin
                    state_d  = ST_IDLE;
                    wb_d.cyc = 1'b0;
                    wb_d.stb = 1'b0;
                    wb_d.we  = 1'b0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            wb_q       <= '0;
            dst_q      <= '0;
            idx_q      <= '0;
            op_data_q  <= '0;
            op_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            dst_q      <= dst_d;
            idx_q      <= idx_d;
            op_data_q  <= op_data_d;
            op_valid_q <= op_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign wbm_cyc_o  = wb_q.cyc;
    assign wbm_stb_o  = wb_q.stb;
    assign wbm_we_o   = wb_q.we;
    assign wbm_sel_o  = wb_q.sel;
    assign wbm_adr_o  = wb_q.adr;
    assign wbm_dat_o  = wb_q.dat;
    assign op_data_o  = op_data_q;
    assign op_valid_o = op_valid_q;

endmodule

// File: tb/tb_wb_mac_fetch.sv
// Scoreboard bench for wb_mac_fetch: stimulus pushes expected events, a responder and a
// monitor pop and compare them as the DUT produces bus beats, op_valid and done pulses.
module tb_wb_mac_fetch;

    localparam int unsigned NW  = 8;
    localparam int unsigned RW  = 28;
    localparam int unsigned TO  = 255;
    localparam int unsigned OPW = NW * 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [31:0]     src_adr_i = '0;
    logic [31:0]     dst_adr_i = '0;
    logic            busy_o, done_o, err_o;
    logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]      wbm_sel_o;
    logic [31:0]     wbm_adr_o, wbm_dat_o;
    logic [31:0]     wbm_dat_i = '0;
    logic            wbm_ack_i = 1'b0;
    logic            wbm_err_i = 1'b0;
    logic [OPW-1:0]  op_data_o;
    logic            op_valid_o;
    logic [RW-1:0]   res_i = '0;
    logic            res_valid_i = 1'b0;

    always #5 clk = ~clk;

    wb_mac_fetch #(.NWORDS(NW), .RES_W(RW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i),
        .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .op_data_o(op_data_o), .op_valid_o(op_valid_o),
        .res_i(res_i), .res_valid_i(res_valid_i)
    );

    int compared = 0;
    int mismatched = 0;

    function automatic void check(string nm, logic [OPW-1:0] act, logic [OPW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void flag(string nm);
        compared++;
        mismatched++;
        $display("FAIL %s: event occurred with nothing expected", nm);
    endfunction

    typedef struct {
        logic           err;
        logic           has_wr;
        logic [31:0]    wadr;
        logic [31:0]    wdat;
        logic [OPW-1:0] op;
    } end_t;

    end_t           end_q[$];
    logic [OPW-1:0] op_q[$];
    logic [31:0]    adr_q[$];
    logic [63:0]    wr_q[$];

    // Reference memory and the operand vector the MAC should currently be seeing
    logic [31:0]    mem [logic [31:0]];
    logic [OPW-1:0] model_op = '0;

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    int hang_beat = -1;
    int err_rd_beat = -1;
    bit err_wr = 1'b0;
    int ack_max = 0;
    bit noise = 1'b0;

    int rd_beat = 0;
    int wait_left = 0;
    int hang_cycles = 0;
    bit hanging = 1'b0;

    // Wishbone target model
    always @(negedge clk) begin : responder
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (!rst_n) begin
            hanging     = 1'b0;
            hang_cycles = 0;
            rd_beat     = 0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (!wbm_we_o && rd_beat == hang_beat) begin
                hanging = 1'b1;
                hang_cycles++;
            end else if (wait_left > 0) begin
                wait_left--;
            end else begin
                wbm_ack_i = 1'b1;
                wait_left = $urandom_range(ack_max, 0);
                if (!wbm_we_o) begin
                    wbm_dat_i = mem_rd(wbm_adr_o);
                    check("read_sel", OPW'(wbm_sel_o), OPW'(4'hF));
                    if (adr_q.size() == 0) flag("unexpected_read");
                    else check("read_adr", OPW'(wbm_adr_o), OPW'(adr_q.pop_front()));
                    if (rd_beat == err_rd_beat) wbm_err_i = 1'b1;
                    rd_beat++;
                end else if (err_wr) begin
                    wbm_err_i = 1'b1;
                end else begin
                    check("write_sel", OPW'(wbm_sel_o), OPW'(4'hF));
                    wr_q.push_back({wbm_adr_o, wbm_dat_o});
                end
            end
        end else begin
            if (!wbm_cyc_o) rd_beat = 0;
            if (hanging) begin
                check("timeout_cycles", OPW'(hang_cycles), OPW'(TO));
                hanging     = 1'b0;
                hang_cycles = 0;
            end
            if (noise) begin
                wbm_ack_i = 1'($urandom_range(1, 0));
                wbm_err_i = 1'($urandom_range(1, 0));
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (rst_n) begin
            if (op_valid_o) begin
                if (op_q.size() == 0) flag("unexpected_op_valid");
                else begin
                    check("op_data", op_data_o, op_q.pop_front());
                    check("op_busy", OPW'(busy_o), OPW'(1));
                    check("op_cyc_low", OPW'(wbm_cyc_o), OPW'(0));
                end
            end
            if (err_o) check("err_with_done", OPW'(done_o), OPW'(1));
            if (done_o) begin
                if (end_q.size() == 0) flag("unexpected_done");
                else begin
                    end_t e;
                    e = end_q.pop_front();
                    check("end_err", OPW'(err_o), OPW'(e.err));
                    check("end_op_data", op_data_o, e.op);
                    check("end_busy", OPW'(busy_o), OPW'(0));
                    check("end_cyc_low", OPW'({wbm_cyc_o, wbm_stb_o}), OPW'(0));
                    if (e.has_wr) begin
                        if (wr_q.size() == 0) flag("missing_write");
                        else begin
                            logic [63:0] w;
                            w = wr_q.pop_front();
                            check("write_adr", OPW'(w[63:32]), OPW'(e.wadr));
                            check("write_dat", OPW'(w[31:0]), OPW'(e.wdat));
                        end
                    end
                    check("extra_writes", OPW'(wr_q.size()), OPW'(0));
                end
            end
        end
    end

    // kind: 0 clean job, 1 read beat fbeat never acked, 2 ack+err on read beat fbeat, 3 ack+err on write
    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [RW-1:0] res,
                           input int kind, input int fbeat, input bit disturb);
        int   nstore;
        int   n;
        end_t e;
        nstore = (kind == 1 || kind == 2) ? fbeat : NW;
        for (int k = 0; k < nstore; k++) begin
            model_op[k*32 +: 32] = mem_rd(src + 32'(4 * k));
            adr_q.push_back(src + 32'(4 * k));
        end
        if (kind == 2) adr_q.push_back(src + 32'(4 * fbeat));
        if (kind == 0 || kind == 3) op_q.push_back(model_op);
        e.err    = (kind != 0);
        e.has_wr = (kind == 0);
        e.wadr   = dst;
        e.wdat   = 32'(res);
        e.op     = model_op;
        end_q.push_back(e);
        hang_beat   = (kind == 1) ? fbeat : -1;
        err_rd_beat = (kind == 2) ? fbeat : -1;
        err_wr      = (kind == 3);

        start_i = 1'b1;
        src_adr_i = src;
        dst_adr_i = dst;
        @(negedge clk);
        start_i = 1'b0;
        if (disturb) begin
            @(negedge clk);
            start_i = 1'b1;
            src_adr_i = $urandom;
            dst_adr_i = $urandom;
            res_valid_i = 1'b1;
            res_i = RW'($urandom);
            @(negedge clk);
            start_i = 1'b0;
            res_valid_i = 1'b0;
        end
        if (kind == 0 || kind == 3) begin
            n = 0;
            while (!op_valid_o && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) begin
                flag("wait_op_valid_expired");
                return;
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
            res_valid_i = 1'b1;
            res_i = res;
            @(negedge clk);
            res_valid_i = 1'b0;
            res_i = RW'($urandom);
        end
        n = 0;
        while (!done_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) flag("wait_done_expired");
    endtask

    task automatic fill_mem(input logic [31:0] base);
        for (int k = 0; k < NW; k++) mem[base + 32'(4 * k)] = $urandom;
    endtask

    initial begin : stimulus
        logic [31:0] src, dst;
        int kind, n;
        repeat (3) @(negedge clk);
        check("rst_cyc_stb_we", OPW'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), OPW'(0));
        check("rst_busy_done_err", OPW'({busy_o, done_o, err_o, op_valid_o}), OPW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sel", OPW'(wbm_sel_o), OPW'(0));
        check("rst_adr", OPW'(wbm_adr_o), OPW'(0));
        check("rst_dat", OPW'(wbm_dat_o), OPW'(0));
        check("rst_op_data", op_data_o, OPW'(0));
        check("idle_busy", OPW'(busy_o), OPW'(0));

        // Nominal job with single-cycle acks
        for (int k = 0; k < NW; k++) mem[32'h100 + 32'(4 * k)] = 32'h1111_1111 * 32'(k + 1);
        ack_max = 0;
        run_job(32'h100, 32'h200, 28'h0ABCDEF, 0, 0, 0);
        check("nom_word0", OPW'(op_data_o[31:0]), OPW'(32'h1111_1111));
        check("nom_word7", OPW'(op_data_o[255:224]), OPW'(32'h8888_8888));
        repeat (2) @(negedge clk);

        // Third read never acknowledged
        fill_mem(32'h300);
        run_job(32'h300, 32'h400, RW'($urandom), 1, 2, 0);
        check("to_partial", OPW'(op_data_o[63:0]), OPW'({mem[32'h304], mem[32'h300]}));
        repeat (2) @(negedge clk);

        // Ack and err together on the write
        fill_mem(32'h500);
        run_job(32'h500, 32'h600, RW'($urandom), 3, 0, 0);
        repeat (2) @(negedge clk);

        // Start and res_valid during READ are ignored
        fill_mem(32'h700);
        run_job(32'h700, 32'h800, RW'($urandom), 0, 0, 1);
        check("disturb_reads_left", OPW'(adr_q.size()), OPW'(0));
        repeat (2) @(negedge clk);

        // Address wrap, then a job started in the same cycle as done
        fill_mem(32'hFFFF_FFF8);
        fill_mem(32'h0);
        run_job(32'hFFFF_FFF8, 32'hFFFF_FFFC, RW'($urandom), 0, 0, 0);
        fill_mem(32'h900);
        run_job(32'h900, 32'hA00, RW'($urandom), 2, 5, 0);
        repeat (2) @(negedge clk);

        // Randomized jobs
        for (int j = 0; j < 24; j++) begin
            ack_max = $urandom_range(3, 0);
            noise = 1'($urandom_range(1, 0));
            src = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFE0 + 32'(4 * $urandom_range(7, 0))
                                              : {$urandom_range(32'hFFFF, 0), 16'h0} + 32'(4 * $urandom_range(63, 0));
            dst = {$urandom, 2'b00};
            fill_mem(src);
            kind = $urandom_range(9, 0);
            if (kind <= 5 || kind == 9) run_job(src, dst, RW'($urandom), 0, 0, kind == 9);
            else run_job(src, dst, RW'($urandom), kind - 5, $urandom_range(NW - 1, 0), 0);
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        noise = 1'b0;
        ack_max = 0;
        repeat (2) @(negedge clk);

        // Reset asserted while the fifth read is outstanding
        fill_mem(32'hB00);
        for (int k = 0; k < 4; k++) adr_q.push_back(32'hB00 + 32'(4 * k));
        hang_beat = 4;
        err_rd_beat = -1;
        err_wr = 1'b0;
        start_i = 1'b1;
        src_adr_i = 32'hB00;
        dst_adr_i = 32'hC00;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(hanging && hang_cycles >= 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) flag("wait_fifth_read_expired");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc_stb", OPW'({wbm_cyc_o, wbm_stb_o}), OPW'(0));
        check("mid_rst_busy", OPW'(busy_o), OPW'(0));
        check("mid_rst_done_err", OPW'({done_o, err_o}), OPW'(0));
        check("mid_rst_op_data", op_data_o, OPW'(0));
        model_op = '0;
        hang_beat = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_done", OPW'(done_o), OPW'(0));

        fill_mem(32'hD00);
        run_job(32'hD00, 32'hE00, RW'($urandom), 0, 0, 0);
        repeat (4) @(negedge clk);

        check("left_reads", OPW'(adr_q.size()), OPW'(0));
        check("left_op_valid", OPW'(op_q.size()), OPW'(0));
        check("left_done", OPW'(end_q.size()), OPW'(0));
        check("left_writes", OPW'(wr_q.size()), OPW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_mac_fetch.md
WB_MAC_FETCH -- requirements
Module: wb_mac_fetch

Interface
REQ-001 SHALL have parameter NWORDS, default 8: number of 32-bit operand words fetched per job.
REQ-002 SHALL have parameter RES_W, default 28: width of the MAC result.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for a bus ack.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are wb_clk_i (input, 1, clock) and wb_rst_ni (input, 1, reset).
REQ-005 SHALL have the following ports:
- start_i  input  1  job start request
- src_adr_i  input  32  operand base byte address
- dst_adr_i  input  32  result byte address
- busy_o  output  1  high whenever the FSM is not IDLE
- done_o  output  1  one-cycle job-end pulse
- err_o  output  1  one-cycle abort pulse
- wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone initiator controls
- wbm_sel_o  output  4  byte select
- wbm_adr_o  output  32  bus address
- wbm_dat_o  output  32  write data
- wbm_dat_i  input  32  read data
- wbm_ack_i  input  1  bus acknowledge
- wbm_err_i  input  1  bus error
- op_data_o  output  NWORDS*32  assembled operand vector to the MAC
- op_valid_o  output  1  one-cycle operand-ready pulse
- res_i  input  RES_W  MAC result
- res_valid_i  input  1  result-valid strobe

Function
REQ-006 SHALL implement the FSM states IDLE, READ, WAIT_RES and WRITE.
REQ-007 SHALL accept start_i only in IDLE, latch src_adr_i and dst_adr_i, clear the word index and timeout counter, and enter READ on the next edge; start_i SHALL be ignored in any other state.
REQ-008 In READ, SHALL hold wbm_cyc_o=wbm_stb_o=1, wbm_we_o=0, wbm_sel_o=4'hF and wbm_adr_o=src+4*index.
REQ-009 On a READ ack, SHALL store wbm_dat_i into op_data_o[32*index+31:32*index], increment index and reset the timeout counter; stb SHALL stay high for the next beat.
REQ-010 On the NWORDS-th ack, SHALL deassert cyc/stb on the next cycle, pulse op_valid_o for exactly that cycle, and enter WAIT_RES.
REQ-011 SHALL sample res_valid_i only in WAIT_RES; on res_valid_i, SHALL capture res_i and enter WRITE.
REQ-012 In WRITE, SHALL drive cyc=stb=we=1, sel=4'hF, adr=dst and dat={zero-extension, result}; on ack, SHALL deassert the bus, pulse done_o and return to IDLE.
REQ-013 Address arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 gives 32'h0.
REQ-014 In READ or WRITE, if wbm_err_i is asserted, or TIMEOUT cycles elapse without an ack, SHALL drop cyc/stb next cycle, pulse err_o and done_o together, and return to IDLE; op_data_o SHALL retain the partial words.
REQ-015 If wbm_ack_i and wbm_err_i are asserted together, wbm_err_i SHALL take priority.
REQ-016 wbm_ack_i and wbm_err_i SHALL be ignored when wbm_stb_o is low.
REQ-017 A start_i coinciding with a done_o pulse SHALL be accepted, because the FSM is already in IDLE.
REQ-018 done_o, err_o and op_valid_o SHALL be registered outputs.

Reset
REQ-019 On wb_rst_ni low, SHALL asynchronously set the state to IDLE and clear all outputs (cyc, stb, we, sel, adr, dat, op_data_o, op_valid_o, busy_o, done_o, err_o), the index and the timeout counter.
REQ-020 Reset asserted mid-transfer SHALL drop cyc/stb immediately and generate no done_o or err_o pulse.

Structure
REQ-021 SHALL place the state encoding, the NWORDS/RES_W/TIMEOUT defaults and the sel constant 4'hF in a shared package, mac_pkg.
REQ-022 SHALL instantiate one sub-module, wb_ack_timer, a loadable down-counter that asserts an expired flag after TIMEOUT cycles.

Verification
REQ-023 Nominal job: src=0x100, dst=0x200, memory words 0x11111111..0x88888888, 1-cycle ack -> reads at 0x100..0x11C; op_data_o[31:0]=0x11111111 and [255:224]=0x88888888; one op_valid_o pulse; res_i=0x0ABCDEF -> write 0x00ABCDEF to 0x200; one done_o pulse, err_o=0.
REQ-024 Timeout: responder never acks the 3rd read -> after 255 idle cycles cyc drops, err_o=done_o=1 for one cycle, op_data_o[63:0] holds words 0 and 1.
REQ-025 Bus error: ack and err asserted together on the write -> err_o pulse, and the write is not counted as a success.
REQ-026 Start while busy, and res_valid_i while in READ -> both ignored; the job completes normally with exactly 8 reads.
REQ-027 Wrap: src=0xFFFFFFF8 -> read addresses run 0xFFFFFFF8, 0xFFFFFFFC, 0x0 .. 0x14.
REQ-028 Reset asserted during the 5th read -> cyc=stb=0 immediately, busy_o=0, and no done_o pulse.
